// File: rtl/riscv_lsu.sv
// Load/store unit: stalls the core until the handshaked data memory acks, aligns sub-word
// data, and flags misaligned accesses and bus timeouts.
module riscv_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_read,
  input  logic                  ex_write,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_W-1:0]     ex_addr,
  input  logic [DATA_W-1:0]     ex_wdata,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_misalign,
  output logic                  lsu_buserr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  wr,
  output logic                  rd,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int OFF   = (DATA_W == 64) ? 3 : 2;
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W+OFF-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_we;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_misalign;
  logic                  r_buserr;

  logic                  w_access;
  logic [1:0]            w_ex_size;
  logic                  w_ex_mis;
  logic [1:0]            w_size;
  logic [OFF-1:0]        w_lane;
  logic                  w_req;
  logic                  w_done;
  logic                  w_tmo;
  logic [DATA_W-1:0]     w_sh;
  logic [DATA_W-1:0]     w_ext;
  logic                  w_msb;
  int                    w_lim;
  logic                  w_unused;

  assign w_access = ex_valid & (ex_read | ex_write);
  assign w_req    = (r_state == ST_REQ);
  assign w_done   = (r_state == ST_DONE);
  assign w_lane   = r_addr[OFF-1:0];
  assign w_tmo    = w_req & ~mem_ack & (TIMEOUT != 0) & (r_cnt == CNT_W'(TO_M1));
  assign w_unused = ^ex_addr;

  // Access size 0..3 = byte/half/word/dword; dword folds to word on a 32-bit datapath.
  always_comb begin
    w_ex_size = ex_funct3[1:0];
    if (w_ex_size == 2'd3 && DATA_W != 64) w_ex_size = 2'd2;
    w_size = r_funct3[1:0];
    if (w_size == 2'd3 && DATA_W != 64) w_size = 2'd2;
  end

  always_comb begin
    w_ex_mis = 1'b0;
    unique case (w_ex_size)
      2'd1:    w_ex_mis = ex_addr[0];
      2'd2:    w_ex_mis = |ex_addr[1:0];
      2'd3:    w_ex_mis = |ex_addr[2:0];
      default: w_ex_mis = 1'b0;
    endcase
  end

  always_comb begin
    mem_be    = {BE_W{1'b1}};
    mem_wdata = r_wdata;
    unique case (w_size)
      2'd0: begin
        mem_be    = BE_W'(1) << w_lane;
        mem_wdata = {BE_W{r_wdata[7:0]}};
      end
      2'd1: begin
        mem_be    = BE_W'(3) << w_lane;
        mem_wdata = {(DATA_W/16){r_wdata[15:0]}};
      end
      2'd2: begin
        mem_be    = BE_W'(15) << w_lane;
        mem_wdata = {(DATA_W/32){r_wdata[31:0]}};
      end
      default: begin
        mem_be    = {BE_W{1'b1}};
        mem_wdata = r_wdata;
      end
    endcase
    if (!r_we) mem_be = {BE_W{1'b1}};
  end

  // Shift the addressed lane down to bit 0, then extend above the access width.
  always_comb begin
    w_sh = mem_rdata >> {w_lane, 3'b000};
    unique case (w_size)
      2'd0:    begin w_lim = 8;      w_msb = w_sh[7];        end
      2'd1:    begin w_lim = 16;     w_msb = w_sh[15];       end
      2'd2:    begin w_lim = 32;     w_msb = w_sh[31];       end
      default: begin w_lim = DATA_W; w_msb = w_sh[DATA_W-1]; end
    endcase
    w_ext = w_sh;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= w_lim) w_ext[i] = ~r_funct3[2] & w_msb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_funct3   <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_rdata <= '0;
          if (w_access) begin
            r_addr     <= ex_addr[ADDR_W+OFF-1:0];
            r_funct3   <= ex_funct3;
            r_wdata    <= ex_wdata;
            r_we       <= ex_write;
            r_cnt      <= '0;
            r_buserr   <= 1'b0;
            r_misalign <= w_ex_mis;
            r_state    <= w_ex_mis ? ST_ERR : ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_ack) begin
            r_rdata <= r_we ? '0 : w_ext;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_buserr <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_ERR:  r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lsu_stall    = ((r_state == ST_IDLE) & w_access) | w_req | (r_state == ST_ERR);
  assign lsu_done     = w_done;
  assign lsu_rdata    = r_rdata;
  assign lsu_misalign = w_done & r_misalign;
  assign lsu_buserr   = w_done & r_buserr;
  assign mem_req      = w_req;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr[ADDR_W+OFF-1:OFF];

  assign wr      = w_done & r_we & ~r_misalign & ~r_buserr;
  assign rd      = w_done & ~r_we & ~r_misalign & ~r_buserr;
  assign addr    = (wr | rd) ? mem_addr : '0;
  assign wr_data = wr ? mem_wdata : '0;
  assign rd_data = rd ? r_rdata : '0;

endmodule
